// File: rtl/adc_spi_responder.sv
// Serial ADC responder emulating an MCP3201-style 12-bit SPI converter.
// Oversamples the master's chip select and serial clock on the system clock
// and serves a held parallel sample as: null bit, MSB-first word, then an
// LSB-first retransmission of B1..B(W-1), followed by zeros.
module adc_spi_responder #(
    parameter int DATA_WIDTH  = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_n,
    input  logic                  sclk,
    input  logic [DATA_WIDTH-1:0] sample_in,
    input  logic                  sample_valid,
    output logic                  data_out,
    output logic                  data_oe,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  frame_abort
);

    localparam int N_MAX    = 31;
    localparam int MSB_LAST = DATA_WIDTH + 2;
    localparam int LSB_LAST = 2 * DATA_WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        SHIFT
    } state_t;

    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic                   cs_prev;
    logic                   sclk_prev;
    logic [SYNC_STAGES:0]   warm;
    logic                   cs_now;
    logic                   sclk_now;
    logic                   cs_fall;
    logic                   cs_rise;
    logic                   sclk_fall;
    logic                   warm_done;

    state_t                 state;
    state_t                 state_next;
    logic [4:0]             n;
    logic [4:0]             n_next;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_next;
    logic [DATA_WIDTH-1:0]  hold_reg;
    logic [DATA_WIDTH-1:0]  hold_next;
    logic                   data_out_next;
    logic                   data_oe_next;
    logic                   frame_done_next;
    logic                   frame_abort_next;
    int                     n_cur;
    int                     n_inc;
    int                     bit_idx;
    logic                   data_bit;

    // Synchronizer chains plus one delayed copy for edge detection; the warm-up
    // chain marks when the delayed copies reflect the real pins after reset, so
    // the reset value of cs_n cannot fake a falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_sync   <= '1;
            sclk_sync <= '0;
            cs_prev   <= 1'b1;
            sclk_prev <= 1'b0;
            warm      <= '0;
        end else begin
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            cs_prev   <= cs_sync[SYNC_STAGES-1];
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            warm      <= {warm[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign cs_now    = cs_sync[SYNC_STAGES-1];
    assign sclk_now  = sclk_sync[SYNC_STAGES-1];
    assign cs_fall   = cs_prev & ~cs_now;
    assign cs_rise   = ~cs_prev & cs_now;
    assign sclk_fall = sclk_prev & ~sclk_now;
    assign warm_done = warm[SYNC_STAGES];
    assign busy      = (state != IDLE);

    // State register, edge counter, sample registers and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            n           <= '0;
            shift_reg   <= '0;
            hold_reg    <= '0;
            data_out    <= 1'b0;
            data_oe     <= 1'b0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state       <= state_next;
            n           <= n_next;
            shift_reg   <= shift_next;
            hold_reg    <= hold_next;
            data_out    <= data_out_next;
            data_oe     <= data_oe_next;
            frame_done  <= frame_done_next;
            frame_abort <= frame_abort_next;
        end
    end

    // Next-state logic: frame start copies the sample (bypassing the hold register
    // on a coincident strobe), each sclk fall picks the bit for the new count, and
    // a cs_n rise ends the frame, winning over a same-cycle sclk fall.
    always_comb begin
        state_next       = state;
        n_next           = n;
        shift_next       = shift_reg;
        hold_next        = hold_reg;
        data_out_next    = data_out;
        data_oe_next     = data_oe;
        frame_done_next  = 1'b0;
        frame_abort_next = 1'b0;
        n_cur            = {27'd0, n};
        n_inc            = 0;
        bit_idx          = 0;
        data_bit         = 1'b0;

        if (sample_valid) begin
            hold_next = sample_in;
        end

        case (state)
            IDLE: begin
                data_oe_next  = 1'b0;
                data_out_next = 1'b0;
                if (cs_fall && warm_done) begin
                    state_next = SAMPLE;
                    n_next     = '0;
                    shift_next = sample_valid ? sample_in : hold_reg;
                end
            end
            SAMPLE, SHIFT: begin
                if (cs_rise) begin
                    state_next    = IDLE;
                    data_oe_next  = 1'b0;
                    data_out_next = 1'b0;
                    if (n_cur >= MSB_LAST) begin
                        frame_done_next = 1'b1;
                    end else begin
                        frame_abort_next = 1'b1;
                    end
                end else if (sclk_fall && !cs_now) begin
                    n_inc  = (n_cur >= N_MAX) ? N_MAX : n_cur + 1;
                    n_next = n_inc[4:0];
                    if (n_inc >= 2) begin
                        if (n_inc >= 3 && n_inc <= MSB_LAST) begin
                            bit_idx = MSB_LAST - n_inc;
                        end else if (n_inc > MSB_LAST && n_inc <= LSB_LAST) begin
                            bit_idx = n_inc - 2 - DATA_WIDTH;
                        end else begin
                            bit_idx = -1;
                        end
                        for (int b = 0; b < DATA_WIDTH; b++) begin
                            if (b == bit_idx) begin
                                data_bit = shift_reg[b];
                            end
                        end
                        state_next    = SHIFT;
                        data_oe_next  = 1'b1;
                        data_out_next = data_bit;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_adc_spi_responder.sv
// Testbench for adc_spi_responder: acts as the SPI master at 1 MHz, pushes the
// bit each falling edge should produce onto a scoreboard and compares it when
// the master samples just before the next rising edge.
module tb_adc_spi_responder;

    localparam int HALF = 25;

    typedef struct {
        logic oe;
        logic d;
        int   idx;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        cs_n;
    logic        sclk;
    logic [11:0] sample_in;
    logic        sample_valid;
    logic        data_out;
    logic        data_oe;
    logic        busy;
    logic        frame_done;
    logic        frame_abort;

    int   checks;
    int   passes;
    int   done_count;
    int   abort_count;
    exp_t sb[$];

    adc_spi_responder #(
        .DATA_WIDTH (12),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cs_n        (cs_n),
        .sclk        (sclk),
        .sample_in   (sample_in),
        .sample_valid(sample_valid),
        .data_out    (data_out),
        .data_oe     (data_oe),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
    );

    // 50 MHz system clock.
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Count pulse cycles so each frame can check it saw exactly one.
    always @(negedge clk) begin
        if (frame_done) done_count++;
        if (frame_abort) abort_count++;
    end

    // Keep the run bounded even if something goes badly wrong.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic wait_cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    function automatic void expected_at(input logic [11:0] v, input int i,
                                        output logic oe, output logic d);
        logic [11:0] w;
        w  = v;
        oe = (i >= 2);
        d  = 1'b0;
        if (i >= 3 && i <= 14) d = w[14 - i];
        else if (i >= 15 && i <= 25) d = w[i - 14];
    endfunction

    task automatic load_sample(input logic [11:0] v);
        @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    task automatic run_frame(input string name, input int edges, input logic [11:0] served,
                             input bit expect_done, input bit bypass_en,
                             input logic [11:0] bypass_val, input int mid_edge,
                             input logic [11:0] mid_val);
        exp_t e;
        exp_t got;
        int   done0;
        int   abort0;
        done0  = done_count;
        abort0 = abort_count;
        @(negedge clk);
        cs_n = 1'b0;
        if (bypass_en) begin
            wait_cycles(2);
            sample_in    = bypass_val;
            sample_valid = 1'b1;
            wait_cycles(1);
            sample_valid = 1'b0;
            wait_cycles(HALF - 3);
        end else begin
            wait_cycles(HALF);
        end
        for (int i = 1; i <= edges; i++) begin
            sclk = 1'b1;
            if (i == mid_edge) begin
                wait_cycles(1);
                sample_in    = mid_val;
                sample_valid = 1'b1;
                wait_cycles(1);
                sample_valid = 1'b0;
                wait_cycles(HALF - 2);
            end else begin
                wait_cycles(HALF);
            end
            sclk = 1'b0;
            expected_at(served, i, e.oe, e.d);
            e.idx = i;
            sb.push_back(e);
            if (i == 2) begin
                wait_cycles(2);
                checks++;
                if (data_oe !== 1'b0)
                    $display("[TB] FAIL %s oe_latency_early: got %b expected 0", name, data_oe);
                else passes++;
                wait_cycles(1);
                checks++;
                if (data_oe !== 1'b1)
                    $display("[TB] FAIL %s oe_latency: got %b expected 1", name, data_oe);
                else passes++;
                wait_cycles(HALF - 3);
            end else begin
                wait_cycles(HALF);
            end
            got = sb.pop_front();
            checks++;
            if (data_out !== got.d)
                $display("[TB] FAIL %s data_out edge %0d: got %b expected %b", name, got.idx, data_out, got.d);
            else passes++;
            checks++;
            if (data_oe !== got.oe)
                $display("[TB] FAIL %s data_oe edge %0d: got %b expected %b", name, got.idx, data_oe, got.oe);
            else passes++;
            checks++;
            if (busy !== 1'b1)
                $display("[TB] FAIL %s busy edge %0d: got %b expected 1", name, got.idx, busy);
            else passes++;
        end
        cs_n = 1'b1;
        wait_cycles(2);
        checks++;
        if (data_oe !== 1'b1 || busy !== 1'b1)
            $display("[TB] FAIL %s release_early: got oe=%b busy=%b expected 1 1", name, data_oe, busy);
        else passes++;
        wait_cycles(1);
        checks++;
        if (data_oe !== 1'b0 || busy !== 1'b0 || data_out !== 1'b0)
            $display("[TB] FAIL %s release: got oe=%b busy=%b d=%b expected 0 0 0", name, data_oe, busy, data_out);
        else passes++;
        checks++;
        if (frame_done !== expect_done || frame_abort !== !expect_done)
            $display("[TB] FAIL %s pulse_timing: got done=%b abort=%b expected %b %b",
                     name, frame_done, frame_abort, expect_done, !expect_done);
        else passes++;
        wait_cycles(5);
        checks++;
        if ((done_count - done0) !== (expect_done ? 1 : 0))
            $display("[TB] FAIL %s done_count: got %0d expected %0d", name, done_count - done0, expect_done ? 1 : 0);
        else passes++;
        checks++;
        if ((abort_count - abort0) !== (expect_done ? 0 : 1))
            $display("[TB] FAIL %s abort_count: got %0d expected %0d", name, abort_count - abort0, expect_done ? 0 : 1);
        else passes++;
        wait_cycles(HALF);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        cs_n         = 1'b1;
        sclk         = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        wait_cycles(3);
        checks++;
        if ({data_out, data_oe, busy, frame_done, frame_abort} !== 5'b0)
            $display("[TB] FAIL reset_outputs: got %b expected 00000",
                     {data_out, data_oe, busy, frame_done, frame_abort});
        else passes++;
        reset = 1'b0;
        wait_cycles(5);
    endtask

    task automatic test_nominal();
        load_sample(12'hA5C);
        run_frame("nominal", 15, 12'hA5C, 1'b1, 1'b0, '0, 0, '0);
    endtask

    task automatic test_lsb_tail();
        load_sample(12'h801);
        run_frame("lsb_tail", 28, 12'h801, 1'b1, 1'b0, '0, 0, '0);
    endtask

    task automatic test_abort();
        load_sample(12'h3A7);
        run_frame("abort", 6, 12'h3A7, 1'b0, 1'b0, '0, 0, '0);
    endtask

    task automatic test_bypass_hold_update();
        load_sample(12'h5A5);
        run_frame("bypass", 15, 12'h123, 1'b1, 1'b1, 12'h123, 7, 12'hFFF);
        run_frame("hold_update", 15, 12'hFFF, 1'b1, 1'b0, '0, 0, '0);
    endtask

    task automatic test_reset_mid_frame();
        int done0;
        int abort0;
        load_sample(12'h6B2);
        @(negedge clk);
        cs_n = 1'b0;
        wait_cycles(HALF);
        for (int i = 1; i <= 8; i++) begin
            sclk = 1'b1;
            wait_cycles(HALF);
            sclk = 1'b0;
            if (i < 8) wait_cycles(HALF);
        end
        wait_cycles(5);
        checks++;
        if (data_oe !== 1'b1)
            $display("[TB] FAIL mid_reset_pre: got oe=%b expected 1", data_oe);
        else passes++;
        done0  = done_count;
        abort0 = abort_count;
        reset = 1'b1;
        wait_cycles(1);
        checks++;
        if ({data_out, data_oe, busy, frame_done, frame_abort} !== 5'b0)
            $display("[TB] FAIL mid_reset_outputs: got %b expected 00000",
                     {data_out, data_oe, busy, frame_done, frame_abort});
        else passes++;
        wait_cycles(1);
        reset = 1'b0;
        wait_cycles(HALF - 7);
        for (int j = 0; j < 4; j++) begin
            sclk = 1'b1;
            wait_cycles(HALF);
            sclk = 1'b0;
            wait_cycles(HALF);
            checks++;
            if (data_oe !== 1'b0 || busy !== 1'b0 || data_out !== 1'b0)
                $display("[TB] FAIL post_reset_idle %0d: got oe=%b busy=%b d=%b expected 0 0 0",
                         j, data_oe, busy, data_out);
            else passes++;
        end
        cs_n = 1'b1;
        wait_cycles(HALF);
        checks++;
        if ((done_count - done0) !== 0 || (abort_count - abort0) !== 0)
            $display("[TB] FAIL post_reset_pulses: got %0d expected 0",
                     (done_count - done0) + (abort_count - abort0));
        else passes++;
        run_frame("after_reset_hold0", 15, 12'h000, 1'b1, 1'b0, '0, 0, '0);
        load_sample(12'h3C6);
        run_frame("after_reset", 15, 12'h3C6, 1'b1, 1'b0, '0, 0, '0);
    endtask

    task automatic test_noise();
        int done0;
        int abort0;
        done0  = done_count;
        abort0 = abort_count;
        cs_n   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            sclk = 1'b1;
            wait_cycles(5);
            sclk = 1'b0;
            wait_cycles(5);
            checks++;
            if (data_oe !== 1'b0 || busy !== 1'b0)
                $display("[TB] FAIL noise %0d: got oe=%b busy=%b expected 0 0", i, data_oe, busy);
            else passes++;
        end
        wait_cycles(5);
        checks++;
        if ((done_count - done0) !== 0 || (abort_count - abort0) !== 0)
            $display("[TB] FAIL noise_pulses: got %0d expected 0",
                     (done_count - done0) + (abort_count - abort0));
        else passes++;
    endtask

    // Test sequence.
    initial begin
        checks      = 0;
        passes      = 0;
        done_count  = 0;
        abort_count = 0;
        test_reset();
        test_nominal();
        test_lsb_tail();
        test_abort();
        test_bypass_hold_update();
        test_reset_mid_frame();
        test_noise();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
